// File: rtl/jet_readout_sched.sv
// jet_readout_sched: snapshots per-slice cluster counts, walks the merge memories and streams phi-tagged jets; define JET_SCHED_ZERO_ET_FILTER_EN to drop zero-et jets.
module jet_readout_sched #(
    parameter int NSLICE     = 27,
    parameter int PHI_W      = 5,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5*NSLICE-1:0]  nclust_bus,
    input  logic [23*NSLICE-1:0] jet_bus,
    output logic [4:0]           jet_addr,
    output logic                 merge_clr,
    output logic [22:0]          out_jet,
    output logic [PHI_W-1:0]     out_phi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int EW = 23 + PHI_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [4:0]       nclust_q [NSLICE];
    logic [4:0]       nclust_d [NSLICE];
    logic [PHI_W-1:0] s_q, s_d;
    logic [4:0]       a_q, a_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [PHI_W-1:0] tag_q [RD_LAT];
    logic [PHI_W-1:0] tag_d [RD_LAT];
    logic [EW-1:0]    fifo_q [FIFO_DEPTH];
    logic [EW-1:0]    fifo_d [FIFO_DEPTH];
    logic [FW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [IW-1:0]    inflight;
    logic [4:0]       cur;
    logic [22:0]      ret_jet;
    logic             issue, wr, pop, credit, last_s;

    // Read-return capture, FIFO bookkeeping, credit-gated issue and the readout FSM.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(tag_vld_q[i]);
        ret_jet = '0;
        for (int k = 0; k < NSLICE; k++)
            if (tag_q[RD_LAT-1] == PHI_W'(k)) ret_jet = jet_bus[23*k +: 23];
`ifdef JET_SCHED_ZERO_ET_FILTER_EN
        wr = tag_vld_q[RD_LAT-1] && ret_jet[8:0] != 9'd0;
`else
        wr = tag_vld_q[RD_LAT-1];
`endif
        out_valid = count_q != '0;
        pop = out_valid && out_ready;
        {out_phi, out_jet} = out_valid ? fifo_q[rd_ptr_q] : '0;
        fifo_d = fifo_q;
        if (wr) fifo_d[wr_ptr_q] = {tag_q[RD_LAT-1], ret_jet};
        wr_ptr_d = wr_ptr_q + FW'(wr);
        rd_ptr_d = rd_ptr_q + FW'(pop);
        count_d = count_q + CW'(wr) - CW'(pop);
        cur = nclust_q[s_q];
        last_s = s_q == PHI_W'(NSLICE - 1);
        // Reads in flight plus buffered words never exceed the FIFO, so returns always fit.
        credit = int'(inflight) + int'(count_q) < FIFO_DEPTH;
        issue = state_q == ISSUE && cur != 5'd0 && credit;
        jet_addr = issue ? a_q : 5'h1f;
        state_d = state_q;
        s_d = s_q;
        a_d = a_q;
        nclust_d = nclust_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                s_d = '0;
                a_d = '0;
                for (int k = 0; k < NSLICE; k++) nclust_d[k] = nclust_bus[5*k +: 5];
            end
            ISSUE: if (cur == 5'd0 || (issue && a_q == cur - 5'd1)) begin
                s_d = s_q + PHI_W'(1);
                a_d = '0;
                if (last_s) state_d = DRAIN;
            end else if (issue) a_d = a_q + 5'd1;
            DRAIN: if (inflight == '0 && count_q == CW'(pop)) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
        tag_vld_d[0] = issue;
        tag_d[0] = s_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        overrun_d = overrun_q || (start && state_q != IDLE);
        busy = state_q != IDLE;
        done = state_q == CLEAR;
        merge_clr = done;
        overrun = overrun_q;
    end

    // Control state with synchronous reset; flushing pointers and tag valids empties the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tag_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_vld_q <= tag_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Payload registers; only meaningful while qualified by state or valid bits.
    always_ff @(posedge clk) begin
        nclust_q <= nclust_d;
        s_q      <= s_d;
        a_q      <= a_d;
        tag_q    <= tag_d;
        fifo_q   <= fifo_d;
    end
endmodule

// File: tb/tb_jet_readout_sched.sv
// tb_jet_readout_sched: randomized self-checking bench for jet_readout_sched against a queue-based readout model.
module tb_jet_readout_sched;
    localparam int NS = 27;
    localparam int PW = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset, start, out_ready;
    logic [5*NS-1:0]  nclust_bus;
    logic [23*NS-1:0] jet_bus;
    logic [4:0]  jet_addr;
    logic        merge_clr, out_valid, busy, done, overrun;
    logic [22:0] out_jet;
    logic [PW-1:0] out_phi;

    logic [22:0] mem [NS][32];
    logic [4:0]  mem_addr_q;
    logic [22:0] mem_out_q [NS];
    int n [NS];
    int pass_n = 0;
    int total_n = 0;
    logic [27:0] got [$];
    logic [27:0] exp_q [$];
    int first_valid, done_cnt, done_rel, clr_bad, busy_bad, max_out, stall_bad, issue_n, last_pop;
    logic busy_after, done_after, ov_end;

    jet_readout_sched dut (
        .clk(clk), .reset(reset), .start(start), .nclust_bus(nclust_bus), .jet_bus(jet_bus),
        .jet_addr(jet_addr), .merge_clr(merge_clr), .out_jet(out_jet), .out_phi(out_phi),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Merge memories: registered address then registered data.
    always_ff @(posedge clk) begin
        mem_addr_q <= jet_addr;
        for (int k = 0; k < NS; k++) mem_out_q[k] <= mem[k][mem_addr_q];
    end

    always_comb for (int k = 0; k < NS; k++) jet_bus[23*k +: 23] = mem_out_q[k];

    // Expected stream: every slice in phi order, every address in order, filtered if enabled.
    function automatic void build_exp();
        exp_q.delete();
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < n[k]; a++)
`ifdef JET_SCHED_ZERO_ET_FILTER_EN
                if (mem[k][a][8:0] != 9'd0)
`endif
                    exp_q.push_back({5'(k), mem[k][a]});
    endfunction

    // Done cycle with out_ready always high: one ISSUE cycle per read or empty slice,
    // then done RD_LAT+2 cycles after the last read, but no earlier than ISSUE end + 2.
    function automatic int exp_done();
        int e = 0;
        int l = 0;
        int last = -1;
        for (int k = 0; k < NS; k++) begin
            e += (n[k] > 0) ? n[k] : 1;
            if (n[k] > 0) last = k;
        end
        if (last < 0) return e + 2;
        for (int k = 0; k < last; k++) l += (n[k] > 0) ? n[k] : 1;
        l += n[last];
        return (l + 4 > e + 2) ? l + 4 : e + 2;
    endfunction

    function automatic int stream_errs();
        int e = (got.size() > exp_q.size()) ? got.size() - exp_q.size() : 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic fill_mem();
        logic [22:0] w;
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < 32; a++) begin
                w = 23'($urandom());
                if (w[8:0] == 9'd0) w[0] = 1'b1;
                mem[k][a] = w;
            end
    endtask

    // Runs one event from a start pulse and records what the DUT did; mode 0 ready high,
    // mode 1 ready low for stall_n cycles, mode 2 random ready.
    task automatic run_readout(input int mode, input int stall_n, input int dup_at, input bit restart);
        logic pv;
        logic [27:0] pw;
        logic r;
        pv = 1'b0;
        pw = '0;
        got.delete();
        first_valid = -1; done_cnt = 0; done_rel = -1; clr_bad = 0; busy_bad = 0;
        max_out = 0; stall_bad = 0; issue_n = 0; last_pop = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < NS; k++) nclust_bus[5*k +: 5] = 5'(n[k]);
        for (int rel = 1; rel < 3000 && done_cnt == 0; rel++) begin
            @(negedge clk);
            start = (rel == dup_at);
            for (int k = 0; k < NS; k++) nclust_bus[5*k +: 5] = 5'($urandom());
            if (jet_addr != 5'h1f) issue_n++;
            if (issue_n - got.size() > max_out) max_out = issue_n - got.size();
            if (pv && (out_valid !== 1'b1 || {out_phi, out_jet} !== pw)) stall_bad++;
            r = (mode == 0) || (mode == 1 && rel > stall_n) || (mode == 2 && $urandom_range(0, 2) != 0);
            out_ready = r;
            if (out_valid && first_valid < 0) first_valid = rel;
            if (out_valid && r) begin
                got.push_back({out_phi, out_jet});
                last_pop = rel;
            end
            pv = out_valid && !r;
            pw = {out_phi, out_jet};
            if (busy !== 1'b1) busy_bad++;
            if (done !== merge_clr) clr_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_rel = rel;
            end
            ov_end = overrun;
        end
        if (restart) start = 1'b1;
        else begin
            @(negedge clk);
            busy_after = busy;
            done_after = done;
            out_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; nclust_bus = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_n++; if (jet_addr !== 5'h1f) $display("FAIL reset_addr got %0h want 1f", jet_addr); else pass_n++;
        total_n++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_n++;
        total_n++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_n++;
        total_n++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_n++;
        total_n++; if (merge_clr !== 1'b0) $display("FAIL reset_clr got %b want 0", merge_clr); else pass_n++;
        total_n++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else pass_n++;
        total_n++; if (out_jet !== 23'd0) $display("FAIL reset_jet got %h want 0", out_jet); else pass_n++;
        total_n++; if (out_phi !== 5'd0) $display("FAIL reset_phi got %h want 0", out_phi); else pass_n++;
    endtask

    task automatic test_basic();
        fill_mem();
        n = '{default: 0};
        n[0] = 2; n[2] = 1; n[3] = 3;
        build_exp();
        run_readout(0, 0, -1, 1'b0);
        total_n++; if (got.size() !== 6) $display("FAIL basic_count got %0d want 6", got.size()); else pass_n++;
        total_n++; if (stream_errs() !== 0) $display("FAIL basic_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (first_valid !== 4) $display("FAIL basic_first_valid got %0d want 4", first_valid); else pass_n++;
        total_n++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got %0d want 1", done_cnt); else pass_n++;
        total_n++; if (done_rel !== exp_done()) $display("FAIL basic_done_cycle got %0d want %0d", done_rel, exp_done()); else pass_n++;
        total_n++; if (clr_bad !== 0) $display("FAIL basic_clr_with_done got %0d bad want 0", clr_bad); else pass_n++;
        total_n++; if (busy_bad !== 0) $display("FAIL basic_busy got %0d low cycles want 0", busy_bad); else pass_n++;
        total_n++; if (busy_after !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy_after); else pass_n++;
        total_n++; if (done_after !== 1'b0) $display("FAIL basic_done_width got %b want 0", done_after); else pass_n++;
    endtask

    task automatic test_all_empty();
        n = '{default: 0};
        build_exp();
        run_readout(0, 0, -1, 1'b0);
        total_n++; if (got.size() !== 0) $display("FAIL empty_count got %0d want 0", got.size()); else pass_n++;
        total_n++; if (first_valid !== -1) $display("FAIL empty_valid got %0d want -1", first_valid); else pass_n++;
        total_n++; if (done_cnt !== 1) $display("FAIL empty_done_cnt got %0d want 1", done_cnt); else pass_n++;
        total_n++; if (done_rel !== NS + 2) $display("FAIL empty_done_cycle got %0d want %0d", done_rel, NS + 2); else pass_n++;
        total_n++; if (busy_bad !== 0) $display("FAIL empty_busy got %0d low cycles want 0", busy_bad); else pass_n++;
        total_n++; if (busy_after !== 1'b0) $display("FAIL empty_busy_after got %b want 0", busy_after); else pass_n++;
    endtask

    task automatic test_backpressure();
        fill_mem();
        n = '{default: 0};
        n[0] = 31;
        build_exp();
        run_readout(1, 20, -1, 1'b0);
        total_n++; if (got.size() !== 31) $display("FAIL bp_count got %0d want 31", got.size()); else pass_n++;
        total_n++; if (stream_errs() !== 0) $display("FAIL bp_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (max_out > DEPTH) $display("FAIL bp_buffered got %0d want <= %0d", max_out, DEPTH); else pass_n++;
        total_n++; if (stall_bad !== 0) $display("FAIL bp_stable got %0d changes want 0", stall_bad); else pass_n++;
        total_n++; if (done_cnt !== 1) $display("FAIL bp_done_cnt got %0d want 1", done_cnt); else pass_n++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            fill_mem();
            for (int k = 0; k < NS; k++) n[k] = $urandom_range(0, 4);
            build_exp();
            run_readout(2, 0, -1, 1'b0);
            total_n++; if (stream_errs() !== 0) $display("FAIL rand%0d_stream got %0d bad words want 0", it, stream_errs()); else pass_n++;
            total_n++; if (max_out > DEPTH) $display("FAIL rand%0d_buffered got %0d want <= %0d", it, max_out, DEPTH); else pass_n++;
            total_n++; if (stall_bad !== 0) $display("FAIL rand%0d_stable got %0d changes want 0", it, stall_bad); else pass_n++;
            total_n++; if (done_cnt !== 1) $display("FAIL rand%0d_done_cnt got %0d want 1", it, done_cnt); else pass_n++;
            total_n++; if (clr_bad !== 0) $display("FAIL rand%0d_clr got %0d bad want 0", it, clr_bad); else pass_n++;
            total_n++; if (done_rel <= last_pop) $display("FAIL rand%0d_done_order got %0d want > %0d", it, done_rel, last_pop); else pass_n++;
        end
    endtask

    task automatic test_overrun();
        fill_mem();
        for (int k = 0; k < NS; k++) n[k] = $urandom_range(0, 3);
        n[1] = 4;
        build_exp();
        run_readout(0, 0, 6, 1'b0);
        total_n++; if (ov_end !== 1'b1) $display("FAIL ovr_set got %b want 1", ov_end); else pass_n++;
        total_n++; if (stream_errs() !== 0) $display("FAIL ovr_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (done_rel !== exp_done()) $display("FAIL ovr_done_cycle got %0d want %0d", done_rel, exp_done()); else pass_n++;
        total_n++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else pass_n++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_n++; if (overrun !== 1'b0) $display("FAIL ovr_reset got %b want 0", overrun); else pass_n++;
    endtask

    task automatic test_back_to_back();
        fill_mem();
        for (int k = 0; k < NS; k++) n[k] = $urandom_range(0, 2);
        build_exp();
        run_readout(0, 0, -1, 1'b1);
        total_n++; if (stream_errs() !== 0) $display("FAIL b2b_first_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (done_rel !== exp_done()) $display("FAIL b2b_first_done got %0d want %0d", done_rel, exp_done()); else pass_n++;
        run_readout(0, 0, -1, 1'b0);
        total_n++; if (ov_end !== 1'b1) $display("FAIL b2b_overrun got %b want 1", ov_end); else pass_n++;
        total_n++; if (stream_errs() !== 0) $display("FAIL b2b_second_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (done_rel !== exp_done()) $display("FAIL b2b_second_done got %0d want %0d", done_rel, exp_done()); else pass_n++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        fill_mem();
        n = '{default: 0};
        for (int k = 0; k < 4; k++) n[k] = 5;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < NS; k++) nclust_bus[5*k +: 5] = 5'(n[k]);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_n++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else pass_n++;
        total_n++; if (jet_addr !== 5'h1f) $display("FAIL midrst_addr got %0h want 1f", jet_addr); else pass_n++;
        total_n++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_n++;
        build_exp();
        run_readout(0, 0, -1, 1'b0);
        total_n++; if (got.size() !== 20) $display("FAIL midrst_count got %0d want 20", got.size()); else pass_n++;
        total_n++; if (stream_errs() !== 0) $display("FAIL midrst_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (done_rel !== exp_done()) $display("FAIL midrst_done got %0d want %0d", done_rel, exp_done()); else pass_n++;
    endtask

    task automatic test_filter();
        int want;
        fill_mem();
        n = '{default: 0};
        n[0] = 3;
        mem[0][0][8:0] = 9'd0;
        mem[0][1][8:0] = 9'd7;
        mem[0][2][8:0] = 9'd0;
`ifdef JET_SCHED_ZERO_ET_FILTER_EN
        want = 1;
`else
        want = 3;
`endif
        build_exp();
        run_readout(0, 0, -1, 1'b0);
        total_n++; if (got.size() !== want) $display("FAIL filter_count got %0d want %0d", got.size(), want); else pass_n++;
        total_n++; if (stream_errs() !== 0) $display("FAIL filter_stream got %0d bad words want 0", stream_errs()); else pass_n++;
        total_n++; if (done_rel !== exp_done()) $display("FAIL filter_done got %0d want %0d", done_rel, exp_done()); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_empty();
        test_backpressure();
        test_random();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_filter();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
